// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: time-shares one combinational WIDTH x WIDTH multiplier
// between NUM_REQ requesters. Round-robin grant, operands held on the
// multiplier for MUL_LAT cycles, product registered and returned through a
// valid/ready response port tagged with the owning requester's id.
module mult_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int MUL_LAT = 1,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         mul_x,
  output logic [WIDTH-1:0]         mul_y,
  input  logic [2*WIDTH-1:0]       mul_z,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy,
  output logic [7:0]               ops_done
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  // Reject parameter sets the datapath cannot represent.
  generate
    if (MUL_LAT < 1 || NUM_REQ < 2 || NUM_REQ > 8 || IDW < $clog2(NUM_REQ)) begin : g_bad_param
      $error("mult_share_ctrl: illegal parameters (MUL_LAT>=1, 2<=NUM_REQ<=8, IDW>=clog2(NUM_REQ))");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                          state;
  logic [IDW-1:0]                  rr_ptr;
  logic [CW-1:0]                   cnt;

  // Per-requester operand view: element i is bits [i*WIDTH +: WIDTH].
  logic [NUM_REQ-1:0][WIDTH-1:0]   opa, opb;
  assign opa = req_a;
  assign opb = req_b;

  // Valid vector rotated so that bit 0 is the requester at rr_ptr.
  logic [2*NUM_REQ-1:0]            rot;
  assign rot = {req_valid, req_valid} >> rr_ptr;

  logic [IDW-1:0]                  gnt_id;
  logic                            gnt_hit;
  int                              gsum;

  // Round-robin search: the lowest rotated position with valid set wins.
  always_comb begin
    gnt_id  = '0;
    gnt_hit = 1'b0;
    gsum    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gsum = int'(rr_ptr) + k;
        if (gsum >= NUM_REQ) gsum = gsum - NUM_REQ;
        gnt_id  = IDW'(gsum);
        gnt_hit = 1'b1;
      end
    end
  end

  // Only offer a grant while idle and out of reset; at most one bit set.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && gnt_hit)
      req_ready = NUM_REQ'(1) << gnt_id;
  end

  assign busy = (state != IDLE);

  // Control FSM; operands, response and counters are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_hit) begin
            mul_x  <= opa[gnt_id];
            mul_y  <= opb[gnt_id];
            rsp_id <= gnt_id;
            rr_ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            cnt    <= CW'(MUL_LAT - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          // Operands stay put; sample the product once the hold expires.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= mul_z;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: a cycle model with a response scoreboard on the
// MUL_LAT=1 instance, a vector table of single operations, hand sequences for
// reset, backpressure and mid-op reset, and a 256-op run on a MUL_LAT=3 copy.
module tb_mult_share_ctrl;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int ML  = 1;
  localparam int ML2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT1 (MUL_LAT=1)
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   mul_x, mul_y;
  logic [2*W-1:0] mul_z;
  logic           rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;
  logic [7:0]     ops_done;

  // DUT2 (MUL_LAT=3)
  logic           rst2;
  logic [N-1:0]   req_valid2, req_ready2;
  logic [N*W-1:0] req_a2, req_b2;
  logic [W-1:0]   mul_x2, mul_y2;
  logic [2*W-1:0] mul_z2;
  logic           rsp_valid2, rsp_ready2;
  logic [2*W-1:0] rsp_data2;
  logic [1:0]     rsp_id2;
  logic           busy2;
  logic [7:0]     ops_done2;

  // Stand-ins for the shared combinational multiplier.
  assign mul_z  = {4'b0, mul_x}  * {4'b0, mul_y};
  assign mul_z2 = {4'b0, mul_x2} * {4'b0, mul_y2};

  mult_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(ML), .IDW(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy), .ops_done(ops_done));

  mult_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(ML2), .IDW(2)) u_dut2 (
    .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .mul_x(mul_x2), .mul_y(mul_y2), .mul_z(mul_z2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
    .rsp_id(rsp_id2), .busy(busy2), .ops_done(ops_done2));

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [1:0]     id;
    logic [7:0]     data;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] id;
  } exp_t;

  int         checks = 0;
  int         failures = 0;

  // Reference model state for DUT1
  int         m_state = 0;   // 0 idle, 1 busy, 2 resp
  int         m_cnt = 0;
  int         m_rr = 0;
  logic [7:0] m_ops = 8'd0;
  bit         m_on = 1'b0;
  int         cycle_n = 0;
  int         hs_cnt = 0;
  exp_t       sb[$];
  int         acc_log[$];
  logic [7:0] last_d;
  logic [1:0] last_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (bound expired or nothing expected) t=%0t", name, $time);
  endtask

  // One DUT1 clock: compare at the falling edge, advance the model, and
  // return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic cyc();
    logic [N-1:0] exp_rdy;
    int           g;
    bit           hit;
    exp_t         e;
    @(negedge clk);
    cycle_n++;
    exp_rdy = '0;
    g       = 0;
    hit     = 1'b0;
    if (!rst && m_state == 0)
      for (int k = N - 1; k >= 0; k--)
        if (req_valid[(m_rr + k) % N]) begin
          g   = (m_rr + k) % N;
          hit = 1'b1;
        end
    if (hit) exp_rdy[g] = 1'b1;
    if (m_on) begin
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
      chk("ops_done", 32'(ops_done), 32'(m_ops));
      if (m_state == 2) begin
        if (sb.size() == 0) fail_now("sb_empty");
        else begin
          chk("sb_data", 32'(rsp_data), 32'(sb[0].d));
          chk("sb_id", 32'(rsp_id), 32'(sb[0].id));
        end
      end
    end
    if (rst) begin
      m_state = 0; m_rr = 0; m_cnt = 0; m_ops = 8'd0; m_on = 1'b1;
      sb.delete();
    end else begin
      case (m_state)
        0: if (hit) begin
          e.d  = 8'(req_a[g*W +: W]) * 8'(req_b[g*W +: W]);
          e.id = 2'(g);
          sb.push_back(e);
          acc_log.push_back(cycle_n);
          m_rr    = (g + 1) % N;
          m_cnt   = ML - 1;
          m_state = 1;
        end
        1: if (m_cnt == 0) m_state = 2; else m_cnt--;
        2: if (rsp_ready) begin
          last_d  = rsp_data;
          last_id = rsp_id;
          if (sb.size() > 0) void'(sb.pop_front());
          m_ops++;
          hs_cnt++;
          m_state = 0;
        end
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one vector and run until its response handshakes.
  task automatic run_vec(input vec_t v);
    int h0;
    bit ok;
    req_valid = v.valid;
    req_a     = v.a;
    req_b     = v.b;
    rsp_ready = 1'b1;
    h0 = hs_cnt;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      cyc();
      if (hs_cnt != h0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("vec_timeout");
    else begin
      chk("vec_data", 32'(last_d), 32'(v.data));
      chk("vec_id", 32'(last_id), 32'(v.id));
    end
  endtask

  vec_t tbl[10];

  initial begin
    int   h0, lat, n0;
    bit   ok;
    logic [3:0] a, b;

    // Round robin: A[i]=i+1, B[i]=2, all valid
    tbl[0] = '{4'b1111, 16'h4321, 16'h2222, 2'd0, 8'd2};
    tbl[1] = '{4'b1111, 16'h4321, 16'h2222, 2'd1, 8'd4};
    tbl[2] = '{4'b1111, 16'h4321, 16'h2222, 2'd2, 8'd6};
    tbl[3] = '{4'b1111, 16'h4321, 16'h2222, 2'd3, 8'd8};
    tbl[4] = '{4'b1111, 16'h4321, 16'h2222, 2'd0, 8'd2};
    // Pointer wrap and skip (pointer is 2 on entry)
    tbl[5] = '{4'b0100, 16'h0500, 16'h0300, 2'd2, 8'd15};
    tbl[6] = '{4'b0011, 16'h0076, 16'h0023, 2'd0, 8'd18};
    tbl[7] = '{4'b0001, 16'h0009, 16'h0009, 2'd0, 8'd81};
    tbl[8] = '{4'b0011, 16'h00A0, 16'h00B0, 2'd1, 8'd110};
    // Op after mid-op reset
    tbl[9] = '{4'b0010, 16'h0070, 16'h0060, 2'd1, 8'd42};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    rst2 = 1'b1; req_valid2 = '0; req_a2 = '0; req_b2 = '0; rsp_ready2 = 1'b1;

    // Reset with a request pending: no grant while rst is high
    req_valid = 4'b0001; req_a = 16'h0003; req_b = 16'h0005;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_mul_x", 32'(mul_x), 0);
    chk("rst_mul_y", 32'(mul_y), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    #1;
    chk("single_rdy_c0", 32'(req_ready), 32'h1);
    cyc();                       // cycle 0: accept
    req_valid = '0;
    cyc();                       // cycle 1: busy
    chk("single_rsp_valid_c2", 32'(rsp_valid), 1);
    chk("single_rsp_data", 32'(rsp_data), 15);
    chk("single_rsp_id", 32'(rsp_id), 0);
    cyc();                       // cycle 2: handshake
    chk("single_ops_done", 32'(ops_done), 1);

    // Fresh reset, then round robin
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    acc_log.delete();
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);
    req_valid = '0;
    if (acc_log.size() != 5) fail_now("rr_accept_count");
    else for (int i = 1; i < 5; i++)
      chk("rr_spacing", 32'(acc_log[i] - acc_log[i-1]), 32'(ML + 2));

    // Backpressure: 15*15 from requester 1, consumer stalls 5 cycles
    req_valid = 4'b0010; req_a = 16'h00F0; req_b = 16'h00F0; rsp_ready = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      cyc();
    end
    if (!ok) fail_now("bp_rsp_timeout");
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) begin
      chk("bp_data", 32'(rsp_data), 225);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_valid", 32'(rsp_valid), 1);
      cyc();
    end
    req_valid = '0; rsp_ready = 1'b1;
    cyc();
    chk("bp_done_valid", 32'(rsp_valid), 0);
    chk("bp_ops_done", 32'(ops_done), 6);

    // Wrap and skip
    for (int i = 5; i < 9; i++) run_vec(tbl[i]);
    req_valid = '0;

    // Reset in the busy cycle discards the op
    req_valid = 4'b0010; req_a = 16'h0070; req_b = 16'h0060; rsp_ready = 1'b1;
    cyc();                       // accept
    n0 = hs_cnt;
    chk("midop_busy", 32'(busy), 1);
    rst = 1'b1; req_valid = '0;
    cyc();
    rst = 1'b0;
    chk("midop_rsp_valid", 32'(rsp_valid), 0);
    chk("midop_busy_clr", 32'(busy), 0);
    chk("midop_ops_done", 32'(ops_done), 0);
    chk("midop_mul_x", 32'(mul_x), 0);
    chk("midop_mul_y", 32'(mul_y), 0);
    for (int t = 0; t < 3; t++) cyc();
    chk("midop_no_rsp", 32'(hs_cnt), 32'(n0));
    run_vec(tbl[9]);
    req_valid = '0;

    // MUL_LAT=3 instance: latency and ops_done wrap over 256 ops
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    chk("ml3_rst_ops", 32'(ops_done2), 0);
    for (int op = 0; op < 256; op++) begin
      a = 4'(op % 16);
      b = 4'((op * 7 + 3) % 16);
      req_valid2 = 4'b0100;
      req_a2 = 16'(a) << 8;
      req_b2 = 16'(b) << 8;
      #1;
      ok = 1'b0;
      for (int t = 0; t < 10; t++) begin
        if (req_ready2[2]) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) fail_now("ml3_grant_timeout");
      @(posedge clk); #1;        // accept edge; now cycle 1
      req_valid2 = '0;
      if (op == 0) chk("ml3_busy", 32'(busy2), 1);
      lat = 0;
      for (int t = 1; t <= 12; t++) begin
        if (rsp_valid2) begin lat = t; break; end
        @(posedge clk); #1;
      end
      chk("ml3_latency", 32'(lat), 32'(ML2 + 1));
      chk("ml3_data", 32'(rsp_data2), 32'(8'(a) * 8'(b)));
      if (op == 0) chk("ml3_id", 32'(rsp_id2), 2);
      @(posedge clk); #1;        // handshake
      if (op == 254) chk("ml3_ops_255", 32'(ops_done2), 255);
    end
    chk("ml3_ops_wrap", 32'(ops_done2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Time-shares one combinational WIDTH x WIDTH multiplier (the tt_um_mult datapath, X/Y in, Z2 out) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on both the request and response sides, and a registered operand hold with a programmable settle count.
- Sits between the tile's I/O decode logic and the multiplier instance. It owns the multiplier's X/Y inputs and registers its Z2 output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width; product width is 2*WIDTH.
- MUL_LAT, 1, cycles operands are held on the multiplier before Z is sampled (>=1).
- IDW, 2, requester-id width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, packed the same way.
- mul_x  out  WIDTH  to multiplier X.
- mul_y  out  WIDTH  to multiplier Y.
- mul_z  in  2*WIDTH  from multiplier Z2 (combinational product).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_data  out  2*WIDTH  registered product.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- busy  out  1  high whenever state != IDLE.
- ops_done  out  8  completed-operation count; wraps 255 -> 0.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE, rr_ptr=0, cnt=0.
  - mul_x=0, mul_y=0, rsp_data=0, rsp_id=0, rsp_valid=0, busy=0, ops_done=0.
  - req_ready=0 while rst is high.
- Reset mid-operation discards the in-flight op; no response is produced for it.
- State IDLE:
  - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally; every other req_ready bit is 0. If no req_valid, req_ready=0.
  - Accept is req_valid[g]&req_ready[g] at the edge. On accept:
    - mul_x<=req_a[g], mul_y<=req_b[g], rsp_id<=g.
    - rr_ptr<=(g+1) mod NUM_REQ, cnt<=MUL_LAT-1, state<=BUSY.
- State BUSY:
  - req_ready=0. mul_x and mul_y hold their values.
  - If cnt!=0, cnt decrements.
  - If cnt==0: rsp_data<=mul_z, rsp_valid<=1, state<=RESP.
- State RESP:
  - req_ready=0. rsp_valid, rsp_data and rsp_id hold stable until the handshake.
  - On rsp_valid&rsp_ready: rsp_valid<=0, ops_done<=ops_done+1, state<=IDLE.
  - No new request is accepted in the handshake cycle. The minimum request-to-request spacing is MUL_LAT+2 cycles.
- Latency: accept in cycle 0, BUSY in cycles 1..MUL_LAT, rsp_valid high from cycle MUL_LAT+1 when rsp_ready is held high.
- Arithmetic: unsigned. rsp_data is mul_z sampled exactly once, from the held operands. Max result for WIDTH=4 is 15*15=225 (0xE1).
- Fairness:
  - A requester holding req_valid is granted within NUM_REQ grants.
  - rr_ptr advances only on an accept.
  - A req_valid drop while the requester is not granted is legal and is ignored.
- Illegal parameter values (MUL_LAT=0, IDW too small) are caught by an elaboration-time check.
- mul_x and mul_y keep their last value in IDLE and RESP; no glitch toggling.

Test Plan:
- Reset then single op: rst 2 cycles; req_valid=0001, A0=3, B0=5, rsp_ready=1. Required: req_ready=0001 in cycle 0; rsp_valid=1 in cycle 2 (MUL_LAT=1) with rsp_data=15, rsp_id=0; ops_done=1 after the handshake.
- Round-robin: req_valid=1111 held, A[i]=i+1, B[i]=2. Required: grant order 0,1,2,3,0; responses 2,4,6,8,2 with matching rsp_id; each accept spaced MUL_LAT+2 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, with A=15, B=15. Required: rsp_data=225 stable; req_ready stays 0000; busy=1; the response completes once rsp_ready=1.
- Pointer wrap and skip: rr_ptr=3 after a grant to 2; req_valid=0011. Required: next grant 0 and rr_ptr=1; a following request from 0 only is granted 0.
- Reset mid-op: assert rst in the BUSY cycle. Required: next cycle rsp_valid=0, busy=0, ops_done=0, mul_x=mul_y=0, with no response emitted. A later op from requester 1 returns the correct product with rsp_id=1.
- MUL_LAT=3 and ops_done wrap: 256 ops. Required: rsp_valid in cycle 4 after each accept; ops_done reads 0 after op 256.
